// File: rtl/vx_stream_scatter_pkg.sv
// Shared helpers for the stream scatter block: lane-index width derivation.
package vx_stream_scatter_pkg;

  // Lane index width, clamped to at least one bit so a single-lane build still has a port.
  function automatic int lane_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_stream_scatter_if.sv
// Input stream plus per-lane output streams of the scatter block.
interface vx_stream_scatter_if
  import vx_stream_scatter_pkg::*;
#(
  parameter int NUM_OUTPUTS = 4,
  parameter int DATAW       = 32,
  parameter int LANEW       = lane_width(NUM_OUTPUTS)
);

  logic                                valid_in;
  logic [DATAW-1:0]                    data_in;
  logic                                ready_in;
  logic [LANEW-1:0]                    lane_in;
  logic [NUM_OUTPUTS-1:0]              valid_out;
  logic [NUM_OUTPUTS-1:0][DATAW-1:0]   data_out;
  logic [NUM_OUTPUTS-1:0]              ready_out;

  // Producer of the input stream and consumer of the output lanes.
  modport master (
    output valid_in, data_in, ready_out,
    input  ready_in, lane_in, valid_out, data_out
  );

  modport slave (
    input  valid_in, data_in, ready_out,
    output ready_in, lane_in, valid_out, data_out
  );

endinterface

// File: rtl/vx_stream_scatter_lane_select.sv
// Combinational priority encoder: index of the first set request bit, low-first or high-first.
module vx_stream_scatter_lane_select
  import vx_stream_scatter_pkg::*;
#(
  parameter int N       = 4,
  parameter bit REVERSE = 1'b0,
  parameter int LANEW   = lane_width(N)
) (
  input  logic [N-1:0]     req_i,
  output logic [LANEW-1:0] index_o,
  output logic             any_valid_o
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    index_o     = '0;
    any_valid_o = |req_i;
    // The last match in scan order wins, so scan opposite to the desired priority.
    if (REVERSE) begin
      for (int i = 0; i < N; i++) begin
        if (req_i[i]) index_o = LANEW'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req_i[i]) index_o = LANEW'(i);
      end
    end
  end

endmodule

// File: rtl/vx_stream_scatter.sv
// Scatters one valid/ready stream onto the first available of NUM_OUTPUTS registered lanes.
module vx_stream_scatter
  import vx_stream_scatter_pkg::*;
#(
  parameter int NUM_OUTPUTS = 4,
  parameter int DATAW       = 32,
  parameter bit REVERSE     = 1'b0,
  parameter int LANEW       = lane_width(NUM_OUTPUTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_stream_scatter_if.slave   bus
);

  logic [NUM_OUTPUTS-1:0]            valid_q, valid_d;
  logic [NUM_OUTPUTS-1:0][DATAW-1:0] data_q, data_d;
  logic [NUM_OUTPUTS-1:0]            avail;
  logic [NUM_OUTPUTS-1:0]            load;
  logic [LANEW-1:0]                  target;
  logic                              any_avail;
  logic                              accept;

  // A lane draining this cycle counts as free, so it can be reloaded without a bubble.
  assign avail = ~valid_q | bus.ready_out;

  vx_stream_scatter_lane_select #(
    .N       (NUM_OUTPUTS),
    .REVERSE (REVERSE),
    .LANEW   (LANEW)
  ) u_lane_select (
    .req_i       (avail),
    .index_o     (target),
    .any_valid_o (any_avail)
  );

  assign bus.ready_in  = any_avail & ~reset;
  assign bus.lane_in   = target;
  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;

  assign accept = bus.valid_in & bus.ready_in;
  assign load   = accept ? (NUM_OUTPUTS'(1) << target) : '0;

  always_comb begin
    valid_d = load | (valid_q & ~bus.ready_out);
    data_d  = data_q;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      if (load[i]) data_d[i] = bus.data_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // NOTE: payload registers are deliberately not reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  a_valid_in_known: assert property (@(posedge clk) disable iff (reset)
    !$isunknown(bus.valid_in));

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_hold
    a_stall_hold: assert property (@(posedge clk) disable iff (reset)
      (valid_q[g] && !bus.ready_out[g]) |=> (valid_q[g] && $stable(data_q[g])));
  end

endmodule

// File: tb/tb_vx_stream_scatter.sv
// Directed and randomised checks of vx_stream_scatter in forward and reverse priority builds.
module tb_vx_stream_scatter;
  import vx_stream_scatter_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  vx_stream_scatter_if #(.NUM_OUTPUTS(N), .DATAW(W)) if_f ();
  vx_stream_scatter_if #(.NUM_OUTPUTS(N), .DATAW(W)) if_r ();

  vx_stream_scatter #(.NUM_OUTPUTS(N), .DATAW(W), .REVERSE(1'b0)) u_fwd (
    .clk   (clk),
    .reset (reset),
    .bus   (if_f)
  );

  vx_stream_scatter #(.NUM_OUTPUTS(N), .DATAW(W), .REVERSE(1'b1)) u_rev (
    .clk   (clk),
    .reset (reset),
    .bus   (if_r)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_f(input logic v, input logic [W-1:0] d, input logic [N-1:0] r);
    if_f.valid_in  = v;
    if_f.data_in   = d;
    if_f.ready_out = r;
  endtask

  // Soak model state
  logic [N-1:0]        m_valid;
  logic [N-1:0][W-1:0] m_data;
  logic [N-1:0]        m_avail;
  logic                m_ready;
  int                  m_tgt;
  int                  n_in, n_out;

  initial begin
    reset = 1'b1;
    drive_f(1'b0, '0, '0);
    if_r.valid_in  = 1'b0;
    if_r.data_in   = '0;
    if_r.ready_out = '0;

    // Reset behaviour
    tick();
    check("rst_ready_in", 32'(if_f.ready_in), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_valid_out", 32'(if_f.valid_out), 32'h0);
    check("idle_ready_in", 32'(if_f.ready_in), 32'd1);

    // 1: fill lanes 0..3 in order
    for (int k = 0; k < N; k++) begin
      drive_f(1'b1, W'(8'hA1 + k), '0);
      #1;
      check($sformatf("fill_lane_in%0d", k), 32'(if_f.lane_in), 32'(k));
      tick();
      check($sformatf("fill_data%0d", k), 32'(if_f.data_out[k]), 32'(8'hA1 + k));
      check($sformatf("fill_valid%0d", k), 32'(if_f.valid_out), 32'((1 << (k + 1)) - 1));
    end
    drive_f(1'b1, 8'hEE, '0);
    #1;
    check("full_ready_in", 32'(if_f.ready_in), 32'd0);
    tick();
    check("full_valid_hold", 32'(if_f.valid_out), 32'hF);
    check("full_data0_hold", 32'(if_f.data_out[0]), 32'hA1);

    // 2: drain and reload lane 2 in the same cycle
    drive_f(1'b1, 8'hB5, 4'b0100);
    #1;
    check("reload_ready_in", 32'(if_f.ready_in), 32'd1);
    check("reload_lane_in", 32'(if_f.lane_in), 32'd2);
    tick();
    check("reload_valid", 32'(if_f.valid_out), 32'hF);
    check("reload_data2", 32'(if_f.data_out[2]), 32'hB5);
    check("reload_data3", 32'(if_f.data_out[3]), 32'hA4);

    // Drain everything
    drive_f(1'b0, '0, 4'hF);
    tick();
    check("drain_valid", 32'(if_f.valid_out), 32'h0);

    // 4: lane 1 held for 10 cycles, then released
    drive_f(1'b1, 8'h50, '0);
    tick();
    drive_f(1'b1, 8'h5C, '0);
    #1;
    check("hold_lane_in", 32'(if_f.lane_in), 32'd1);
    tick();
    drive_f(1'b0, '0, '0);
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("hold_data1_c%0d", c), 32'(if_f.data_out[1]), 32'h5C);
      check($sformatf("hold_valid1_c%0d", c), 32'(if_f.valid_out[1]), 32'd1);
    end
    drive_f(1'b0, '0, 4'b0010);
    tick();
    check("release_valid", 32'(if_f.valid_out), 32'b0001);
    drive_f(1'b0, '0, '0);

    // 5: fill, then reset mid-operation
    for (int k = 0; k < 3; k++) begin
      drive_f(1'b1, W'(8'hC0 + k), '0);
      tick();
    end
    check("prereset_valid", 32'(if_f.valid_out), 32'hF);
    drive_f(1'b0, '0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_valid", 32'(if_f.valid_out), 32'h0);
    drive_f(1'b1, 8'h77, '0);
    #1;
    check("postreset_lane_in", 32'(if_f.lane_in), 32'd0);
    tick();
    check("postreset_valid", 32'(if_f.valid_out), 32'b0001);
    check("postreset_data0", 32'(if_f.data_out[0]), 32'h77);
    drive_f(1'b0, '0, '0);

    // 3: reverse priority build
    if_r.valid_in = 1'b1;
    if_r.data_in  = 8'h11;
    #1;
    check("rev_lane_in_a", 32'(if_r.lane_in), 32'd3);
    tick();
    check("rev_data3", 32'(if_r.data_out[3]), 32'h11);
    check("rev_valid_a", 32'(if_r.valid_out), 32'b1000);
    if_r.data_in = 8'h22;
    #1;
    check("rev_lane_in_b", 32'(if_r.lane_in), 32'd2);
    tick();
    check("rev_data2", 32'(if_r.data_out[2]), 32'h22);
    check("rev_valid_b", 32'(if_r.valid_out), 32'b1100);
    if_r.valid_in = 1'b0;

    // 6: random soak against a per-lane scoreboard (forward build holds lane 0 = 0x77)
    m_valid   = 4'b0001;
    m_data    = '0;
    m_data[0] = 8'h77;
    n_in      = 1;
    n_out     = 0;
    for (int c = 0; c < 10000; c++) begin
      drive_f(1'($urandom_range(0, 1)), W'($urandom), N'($urandom));
      #1;
      m_avail = ~m_valid | if_f.ready_out;
      m_ready = |m_avail;
      m_tgt   = 0;
      for (int i = N - 1; i >= 0; i--) if (m_avail[i]) m_tgt = i;
      check("soak_ready_in", 32'(if_f.ready_in), 32'(m_ready));
      for (int i = 0; i < N; i++) begin
        if (m_valid[i] && if_f.ready_out[i]) begin
          n_out++;
          m_valid[i] = 1'b0;
        end
      end
      if (if_f.valid_in && m_ready) begin
        check("soak_lane_in", 32'(if_f.lane_in), 32'(m_tgt));
        m_valid[m_tgt] = 1'b1;
        m_data[m_tgt]  = if_f.data_in;
        n_in++;
      end
      tick();
      check("soak_valid", 32'(if_f.valid_out), 32'(m_valid));
      for (int i = 0; i < N; i++) begin
        if (m_valid[i]) check($sformatf("soak_data%0d", i), 32'(if_f.data_out[i]), 32'(m_data[i]));
      end
    end
    check("soak_conservation", 32'(n_in), 32'(n_out + $countones(if_f.valid_out)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
